// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - state encoding, constants and result-fixup helpers for the iterative divider
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        OUT
    } state_t;

    localparam int N_WORD = 32;
    localparam int MAX_W  = 64;

    // Take the low word and widen it: sign-extend for signed ops, zero-extend otherwise.
    function automatic logic [MAX_W-1:0] ext_word(input logic [MAX_W-1:0] v, input logic sgn);
        return {{(MAX_W-N_WORD){sgn & v[N_WORD-1]}}, v[N_WORD-1:0]};
    endfunction

    // Negate when the recorded sign says so; word results always sign-extend bit 31.
    function automatic logic [MAX_W-1:0] fix_result(input logic [MAX_W-1:0] v, input logic neg,
                                                    input logic word);
        logic [MAX_W-1:0] t;
        t = neg ? (~v + 1'b1) : v;
        return word ? {{(MAX_W-N_WORD){t[N_WORD-1]}}, t[N_WORD-1:0]} : t;
    endfunction

endpackage

// File: rtl/div_lzc.sv
// rtl/div_lzc.sv - parametrised leading-zero counter (count = W when value is zero)
module div_lzc #(
    parameter int W = 64
) (
    input  logic [W-1:0]               value,
    output logic [$clog2(W+1)-1:0]     count
);

    localparam int CW = $clog2(W+1);

    always_comb begin
        count = CW'(W);
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider; DIV_LZC_SKIP_EN enables leading-zero skip
module div_iter
    import div_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_signed,
    input  logic            in_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int   CW      = $clog2(XLEN+1);
    localparam logic WORD_EN = (WORD_OPS != 0) && (XLEN == 64);

    state_t          state;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rem;
    logic [CW-1:0]   cnt;
    logic            sgn, word, neg_q, neg_r;

    assign in_ready = (state == IDLE);

    // Request decode: word-mode operand extension and special-case detection.
    logic            acc_word;
    logic [MAX_W-1:0] dd_w, dv_w, dz_rem_w;
    logic [XLEN-1:0] dd_ext, dv_ext;
    logic            div_zero, ovf;

    assign acc_word = in_word & WORD_EN;
    assign dd_w     = ext_word(MAX_W'(dividend), in_signed);
    assign dv_w     = ext_word(MAX_W'(divisor), in_signed);
    assign dd_ext   = acc_word ? dd_w[XLEN-1:0] : dividend;
    assign dv_ext   = acc_word ? dv_w[XLEN-1:0] : divisor;
    assign dz_rem_w = fix_result(MAX_W'(dd_ext), 1'b0, acc_word);
    assign div_zero = (dv_ext == '0);
    assign ovf      = in_signed && (dv_ext == '1) &&
                      (acc_word ? (dd_ext[N_WORD-1:0] == {1'b1, {(N_WORD-1){1'b0}}})
                                : (dd_ext == {1'b1, {(XLEN-1){1'b0}}}));

    logic            sd, sv;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [CW-1:0]   shift, iters;

    assign sd    = sgn & a[XLEN-1];
    assign sv    = sgn & b[XLEN-1];
    assign a_abs = sd ? (~a + 1'b1) : a;
    assign b_abs = sv ? (~b + 1'b1) : b;

`ifdef DIV_LZC_SKIP_EN
    logic [CW-1:0] lz;

    div_lzc #(.W(XLEN)) u_lzc (
        .value (a_abs),
        .count (lz)
    );

    // Word magnitudes have zero upper halves, so the full-width count already covers the word offset.
    assign shift = lz;
    assign iters = CW'(XLEN) - lz;
`else
    assign shift = word ? CW'(XLEN - N_WORD) : '0;
    assign iters = word ? CW'(N_WORD) : CW'(XLEN);
`endif

    // One restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    assign shifted = {rem, a[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, b};

    logic [MAX_W-1:0] q_fix_w, r_fix_w;
    assign q_fix_w = fix_result(MAX_W'(a), neg_q, word);
    assign r_fix_w = fix_result(MAX_W'(rem), neg_r, word);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            a         <= '0;
            b         <= '0;
            rem       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            word      <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn  <= in_signed;
                        word <= acc_word;
                        a    <= dd_ext;
                        b    <= dv_ext;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dz_rem_w[XLEN-1:0];
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else if (ovf) begin
                            quotient  <= dd_ext;
                            remainder <= '0;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            state <= PREP;
                        end
                    end
                end
                PREP: begin
                    neg_q <= sd ^ sv;
                    neg_r <= sd;
                    a     <= a_abs << shift;
                    b     <= b_abs;
                    rem   <= '0;
                    cnt   <= iters;
                    state <= (iters == '0) ? FIX : DIV;
                end
                DIV: begin
                    if (!diff[XLEN+1]) begin
                        rem <= diff[XLEN-1:0];
                        a   <= {a[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= shifted[XLEN-1:0];
                        a   <= {a[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    quotient  <= q_fix_w[XLEN-1:0];
                    remainder <= r_fix_w[XLEN-1:0];
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
